// File: rtl/ceda_frame_ctrl_pkg.sv
// ceda_frame_ctrl_pkg: state encoding, pixel width and width helper shared by the
// CEDA frame controller and its pixel counter.
package ceda_frame_ctrl_pkg;
    localparam int CEDA_PIX_W = 8;
    typedef enum logic [2:0] {S_IDLE, S_WAIT_SOF, S_STREAM, S_FLUSH, S_DRAIN, S_DONE} state_t;
    function automatic int ceda_clog2(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/ceda_px_counter.sv
// ceda_px_counter: column/row position of the current pixel within a frame, with
// first-pixel, end-of-line and end-of-frame decodes.
module ceda_px_counter
    import ceda_frame_ctrl_pkg::*;
#(
    parameter int IMG_WIDTH  = 1920,
    parameter int IMG_HEIGHT = 1080
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    input  logic i_clr,
    output logic o_first,
    output logic o_last_col,
    output logic o_last_pix
);
    localparam int CW = ceda_clog2(IMG_WIDTH);
    localparam int RW = ceda_clog2(IMG_HEIGHT);
    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    assign o_first    = r_col == '0 && r_row == '0;
    assign o_last_col = r_col == CW'(IMG_WIDTH - 1);
    assign o_last_pix = o_last_col && r_row == RW'(IMG_HEIGHT - 1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col <= '0;
            r_row <= '0;
        end else if (i_clr) begin
            r_col <= '0;
            r_row <= '0;
        end else if (i_en) begin
            r_col <= o_last_col ? '0 : r_col + 1'b1;
            if (o_last_col) r_row <= o_last_pix ? '0 : r_row + 1'b1;
        end
    end
endmodule

// File: rtl/ceda_frame_ctrl.sv
// ceda_frame_ctrl: admits whole frames into the CEDA edge pipeline with regenerated
// framing, pads aborted frames, and tracks output lines to report done/timeout.
module ceda_frame_ctrl
    import ceda_frame_ctrl_pkg::*;
#(
    parameter int IMG_WIDTH  = 1920,
    parameter int IMG_HEIGHT = 1080,
    parameter int TO_W       = 24
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_start,
    input  logic                  cfg_continuous,
    input  logic                  cfg_abort,
    input  logic [CEDA_PIX_W-1:0] s_tdata,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    input  logic                  s_tlast,
    input  logic                  s_tuser,
    output logic [CEDA_PIX_W-1:0] p_tdata,
    output logic                  p_tvalid,
    input  logic                  p_tready,
    output logic                  p_tlast,
    output logic                  p_tuser,
    input  logic                  o_tvalid,
    input  logic                  o_tready,
    input  logic                  o_tlast,
    output logic                  sts_busy,
    output logic                  sts_done,
    output logic                  sts_aborted,
    output logic                  sts_err_eol,
    output logic                  sts_err_sof,
    output logic                  sts_timeout,
    output logic [15:0]           sts_frame_cnt,
    output logic [15:0]           sts_drop_cnt
);
    localparam int OW = ceda_clog2(IMG_HEIGHT + 1);
    state_t r_state, w_next;
    logic [OW-1:0] r_ocnt;
    logic [TO_W-1:0] r_idle;
    logic w_first, w_last_col, w_last_pix, w_fwd, w_p_hs, w_s_hs, w_admit, w_rearm, w_drop;
    logic w_o_hs, w_lines_in, w_to;
    assign w_fwd      = r_state == S_STREAM || r_state == S_FLUSH;
    assign w_admit    = r_state == S_IDLE && cfg_start && !cfg_abort;
    assign w_rearm    = r_state == S_DONE && cfg_continuous && !cfg_abort;
    assign w_drop     = r_state == S_WAIT_SOF && s_tvalid && !s_tuser;
    assign w_o_hs     = o_tvalid && o_tready;
    assign w_lines_in = r_ocnt >= OW'(IMG_HEIGHT);
    assign w_to       = r_state == S_DRAIN && !w_lines_in && &r_idle;
    // The SOF beat is held off in WAIT_SOF so it is consumed as pixel 0 in STREAM.
    assign s_tready = (r_state == S_WAIT_SOF && !s_tuser) || (r_state == S_STREAM && p_tready);
    assign p_tvalid = r_state == S_FLUSH || (r_state == S_STREAM && s_tvalid);
    assign p_tdata  = r_state == S_STREAM ? s_tdata : '0;
    assign p_tuser  = w_fwd && w_first;
    assign p_tlast  = w_fwd && w_last_col;
    assign w_p_hs   = w_fwd && p_tvalid && p_tready;
    assign w_s_hs   = r_state == S_STREAM && w_p_hs;
    assign sts_busy = r_state != S_IDLE;
    assign sts_done = r_state == S_DONE;
    ceda_px_counter #(.IMG_WIDTH(IMG_WIDTH), .IMG_HEIGHT(IMG_HEIGHT)) u_px_counter (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_en      (w_p_hs),
        .i_clr     (r_state == S_IDLE || r_state == S_DONE),
        .o_first   (w_first),
        .o_last_col(w_last_col),
        .o_last_pix(w_last_pix)
    );
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     w_next = w_admit ? S_WAIT_SOF : S_IDLE;
            S_WAIT_SOF: w_next = cfg_abort ? S_IDLE : (s_tvalid && s_tuser) ? S_STREAM : S_WAIT_SOF;
            S_STREAM:   w_next = (w_p_hs && w_last_pix) ? S_DRAIN : cfg_abort ? S_FLUSH : S_STREAM;
            S_FLUSH:    w_next = (w_p_hs && w_last_pix) ? S_DRAIN : S_FLUSH;
            S_DRAIN:    w_next = (w_lines_in || w_to) ? S_DONE : S_DRAIN;
            S_DONE:     w_next = w_rearm ? S_WAIT_SOF : S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_ocnt        <= '0;
            r_idle        <= '0;
            sts_aborted   <= 1'b0;
            sts_err_eol   <= 1'b0;
            sts_err_sof   <= 1'b0;
            sts_timeout   <= 1'b0;
            sts_frame_cnt <= '0;
            sts_drop_cnt  <= '0;
        end else begin
            r_state <= w_next;
            r_ocnt  <= (r_state == S_IDLE || r_state == S_DONE) ? '0 : r_ocnt + OW'(w_o_hs && o_tlast);
            r_idle  <= (r_state != S_DRAIN || w_o_hs) ? '0 : r_idle + 1'b1;
            if (w_admit) begin
                sts_aborted <= 1'b0;
                sts_err_eol <= 1'b0;
                sts_err_sof <= 1'b0;
                sts_timeout <= 1'b0;
            end else begin
                if (w_rearm) sts_aborted <= 1'b0;
                if (r_state == S_STREAM && w_next == S_FLUSH) sts_aborted <= 1'b1;
                if (w_s_hs && s_tlast != w_last_col) sts_err_eol <= 1'b1;
                if (w_s_hs && s_tuser && !w_first) sts_err_sof <= 1'b1;
                if (w_to) sts_timeout <= 1'b1;
            end
            if (r_state == S_DONE) sts_frame_cnt <= sts_frame_cnt + 1'b1;
            if (w_drop && !(&sts_drop_cnt)) sts_drop_cnt <= sts_drop_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_ceda_frame_ctrl.sv
// tb_ceda_frame_ctrl: scoreboard bench for the frame sequencer on an 8x4 image with a
// 3-cycle modelled pipeline feeding the output tap.
`timescale 1ns/1ps
module tb_ceda_frame_ctrl;
    localparam int W = 8, H = 4, TO_W = 6, NPIX = W * H;
    typedef struct packed { logic [7:0] d; logic u; logic l; } beat_t;
    typedef struct { int junk; int eol; int sof; int abrt; int drop; logic e_eol; logic e_sof; logic e_ab; } vec_t;

    logic clk = 0, rst_n = 0;
    logic cfg_start = 0, cfg_continuous = 0, cfg_abort = 0;
    logic [7:0] s_tdata = 0, p_tdata;
    logic s_tvalid = 0, s_tready, s_tlast = 0, s_tuser = 0;
    logic p_tvalid, p_tready = 1, p_tlast, p_tuser;
    logic o_tvalid, o_tready, o_tlast;
    logic sts_busy, sts_done, sts_aborted, sts_err_eol, sts_err_sof, sts_timeout;
    logic [15:0] sts_frame_cnt, sts_drop_cnt;
    logic rnd = 0, tap_en = 1;
    logic [2:0] r_pipe;
    beat_t q[$];
    beat_t e;
    int n_chk = 0, n_pass = 0, n_done = 0;
    vec_t tbl[3];

    always #5 clk = ~clk;

    ceda_frame_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .TO_W(TO_W)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_continuous(cfg_continuous),
        .cfg_abort(cfg_abort), .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .s_tlast(s_tlast), .s_tuser(s_tuser), .p_tdata(p_tdata), .p_tvalid(p_tvalid),
        .p_tready(p_tready), .p_tlast(p_tlast), .p_tuser(p_tuser), .o_tvalid(o_tvalid),
        .o_tready(o_tready), .o_tlast(o_tlast), .sts_busy(sts_busy), .sts_done(sts_done),
        .sts_aborted(sts_aborted), .sts_err_eol(sts_err_eol), .sts_err_sof(sts_err_sof),
        .sts_timeout(sts_timeout), .sts_frame_cnt(sts_frame_cnt), .sts_drop_cnt(sts_drop_cnt)
    );

    // Pipeline model: every line end entering the pipeline leaves it 3 cycles later.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_pipe <= '0;
        else r_pipe <= {r_pipe[1:0], p_tvalid & p_tready & p_tlast};
    assign o_tvalid = tap_en & r_pipe[2];
    assign o_tlast  = o_tvalid;
    assign o_tready = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (rst_n && sts_done) n_done++;
        if (rst_n && p_tvalid && p_tready) begin
            if (q.size() == 0) begin
                n_chk++;
                $display("FAIL p_beat: unexpected beat data=0x%0h tuser=%0b tlast=%0b", p_tdata, p_tuser, p_tlast);
            end else begin
                e = q.pop_front();
                chk("p_beat{data,tuser,tlast}", 32'({p_tdata, p_tuser, p_tlast}), 32'(e));
            end
        end
    end

    initial forever begin
        @(posedge clk); #1;
        p_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [7:0] d, input logic u, input logic l);
        int n = 0;
        if (rnd) repeat ($urandom_range(0, 2)) step();
        s_tdata = d; s_tuser = u; s_tlast = l; s_tvalid = 1;
        forever begin
            @(negedge clk);
            if (s_tready) break;
            if (++n > 2000) begin
                n_chk++;
                $display("FAIL send_wait: beat 0x%0h not accepted within %0d cycles", d, n);
                break;
            end
        end
        step();
        s_tvalid = 0; s_tuser = 0; s_tlast = 0;
    endtask

    task automatic pulse_start();
        cfg_start = 1; step(); cfg_start = 0;
        @(negedge clk);
        chk("busy_after_start", 32'(sts_busy), 1);
        step();
    endtask

    task automatic send_frame(input logic [7:0] base, input int eol_bad, input int sof_bad, input int stop_at);
        for (int i = 0; i < NPIX; i++) begin
            if (i == stop_at) break;
            q.push_back({8'(base + i), i == 0, i % W == W - 1});
            send(8'(base + i), i == 0 || i == sof_bad, (i % W == W - 1) ^ (i == eol_bad));
        end
    endtask

    task automatic wait_done();
        int n = 0;
        do begin @(negedge clk); n++; end while (!sts_done && n < 1000);
        if (!sts_done) begin
            n_chk++;
            $display("FAIL done_wait: no done pulse within %0d cycles", n);
        end
        @(negedge clk);
    endtask

    initial begin
        int d0, n;
        tbl[0] = '{3, -1, -1, -1, 3, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{0,  5, 12, -1, 3, 1'b1, 1'b1, 1'b0};
        tbl[2] = '{2, -1, -1, 10, 5, 1'b0, 1'b0, 1'b1};
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(sts_busy), 0);
        chk("rst_s_tready", 32'(s_tready), 0);
        chk("rst_p_tvalid", 32'(p_tvalid), 0);
        chk("rst_frame_cnt", 32'(sts_frame_cnt), 0);
        step(); rst_n = 1; step();
        cfg_start = 1; cfg_abort = 1; step(); cfg_start = 0; cfg_abort = 0;
        @(negedge clk);
        chk("start_abort_same_cycle_busy", 32'(sts_busy), 0);
        step();

        for (int t = 0; t < 3; t++) begin
            d0 = n_done;
            pulse_start();
            for (int j = 0; j < tbl[t].junk; j++) send(8'(8'hE0 + j), 0, 0);
            send_frame(8'(8'h10 + 8'h40 * t), tbl[t].eol, tbl[t].sof, tbl[t].abrt);
            if (tbl[t].abrt >= 0) begin
                for (int i = tbl[t].abrt; i < NPIX; i++) q.push_back({8'h00, 1'b0, i % W == W - 1});
                cfg_abort = 1; step(); cfg_abort = 0;
                @(negedge clk);
                chk("flush_s_tready", 32'(s_tready), 0);
                chk("flush_p_tvalid", 32'(p_tvalid), 1);
                step();
            end
            wait_done();
            chk("vec_done_once", n_done, d0 + 1);
            chk("vec_frame_cnt", 32'(sts_frame_cnt), t + 1);
            chk("vec_drop_cnt", 32'(sts_drop_cnt), tbl[t].drop);
            chk("vec_err_eol", 32'(sts_err_eol), 32'(tbl[t].e_eol));
            chk("vec_err_sof", 32'(sts_err_sof), 32'(tbl[t].e_sof));
            chk("vec_aborted", 32'(sts_aborted), 32'(tbl[t].e_ab));
            chk("vec_busy_idle", 32'(sts_busy), 0);
            chk("vec_queue_empty", q.size(), 0);
            step();
        end

        d0 = n_done; rnd = 1; cfg_continuous = 1;
        pulse_start();
        for (int f = 0; f < 3; f++) send_frame(8'(8'h80 + 8'h20 * f), -1, -1, -1);
        wait_done();
        rnd = 0; cfg_continuous = 0;
        chk("cont_done_pulses", n_done, d0 + 3);
        chk("cont_rearmed_busy", 32'(sts_busy), 1);
        chk("cont_queue_empty", q.size(), 0);
        step(); cfg_abort = 1; step(); cfg_abort = 0;
        @(negedge clk);
        chk("cont_abort_idle", 32'(sts_busy), 0);
        chk("cont_frame_cnt", 32'(sts_frame_cnt), 6);
        step();

        d0 = n_done; tap_en = 0;
        pulse_start();
        send_frame(8'h20, -1, -1, -1);
        n = 0;
        do begin @(negedge clk); n++; end while (!sts_done && n < 200);
        chk("timeout_latency", n, 65);
        chk("timeout_flag", 32'(sts_timeout), 1);
        @(negedge clk);
        chk("timeout_done_once", n_done, d0 + 1);
        chk("timeout_idle", 32'(sts_busy), 0);
        chk("timeout_frame_cnt", 32'(sts_frame_cnt), 7);
        tap_en = 1;
        step();

        pulse_start();
        send_frame(8'h60, -1, -1, 17);
        s_tdata = 8'h71; s_tvalid = 1; rst_n = 0;
        @(negedge clk);
        chk("mid_rst_s_tready", 32'(s_tready), 0);
        chk("mid_rst_p_tvalid", 32'(p_tvalid), 0);
        chk("mid_rst_busy", 32'(sts_busy), 0);
        chk("mid_rst_timeout", 32'(sts_timeout), 0);
        chk("mid_rst_frame_cnt", 32'(sts_frame_cnt), 0);
        chk("mid_rst_drop_cnt", 32'(sts_drop_cnt), 0);
        chk("mid_rst_queue_empty", q.size(), 0);
        s_tvalid = 0; step(); rst_n = 1; step();
        d0 = n_done;
        pulse_start();
        send_frame(8'hC0, -1, -1, -1);
        wait_done();
        chk("post_rst_done_once", n_done, d0 + 1);
        chk("post_rst_frame_cnt", 32'(sts_frame_cnt), 1);
        chk("post_rst_err_eol", 32'(sts_err_eol), 0);
        chk("post_rst_err_sof", 32'(sts_err_sof), 0);
        chk("post_rst_queue_empty", q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
